// File: rtl/boot_uart_loader.sv
// rtl/boot_uart_loader.sv - UART framed boot-image loader writing 32-bit words into boot memory
module boot_uart_loader #(
    parameter int MEM_AW         = 11,
    parameter int TIMEOUT_CYCLES = 80000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_tx_valid,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_ready,
    output logic              o_mem_wr,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [31:0]       o_mem_data,
    output logic              o_cpu_rst,
    output logic              o_busy
);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;
    localparam logic [7:0] RESP_ACK  = 8'h06;
    localparam logic [7:0] RESP_NAK  = 8'h15;

    // Timeout counter must reach TIMEOUT_CYCLES-1 without wrapping.
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // End-of-block word index needs room for the full 16-bit length plus the
    // largest start word address, with headroom so the sum never wraps.
    localparam int SW = ((MEM_AW > 16) ? MEM_AW : 16) + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RESP,
        S_RUN
    } state_t;

    state_t state, state_next;

    logic [1:0]        byte_cnt;
    logic [15:0]       words_left;
    logic [31:0]       addr_sr;
    logic [7:0]        len_hi;
    logic [23:0]       data_sr;
    logic [7:0]        csum;
    logic              run_flag;
    logic              range_err;
    logic              resp_nak;
    logic [MEM_AW-1:0] wr_ptr;
    logic [TW-1:0]     tmo_cnt;

    logic              mem_wr_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [31:0]       mem_data_q;

    logic              rx_state;
    logic              timeout_hit;
    logic [15:0]       len_word;
    logic [SW-1:0]     end_word;
    logic              range_bad;

    assign rx_state    = (state == S_CMD) || (state == S_ADDR) || (state == S_LEN) ||
                         (state == S_DATA) || (state == S_CSUM);
    assign timeout_hit = rx_state && !i_rx_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign len_word    = {len_hi, i_rx_data};
    assign end_word    = SW'(addr_sr[MEM_AW+1:2]) + SW'(len_word);
    assign range_bad   = (addr_sr[1:0] != 2'b00) ||
                         ((addr_sr >> (MEM_AW + 2)) != 32'd0) ||
                         (end_word > SW'(1 << MEM_AW));

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        state_next = state;
        o_tx_valid = 1'b0;
        o_tx_data  = 8'h00;
        o_cpu_rst  = 1'b1;
        o_busy     = 1'b1;
        case (state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_rx_valid && (i_rx_data == SYNC_BYTE)) begin
                    state_next = S_CMD;
                end
            end
            S_CMD: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_WRITE) begin
                        state_next = S_ADDR;
                    end else if (i_rx_data == CMD_RUN) begin
                        state_next = S_CSUM;
                    end else begin
                        state_next = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (i_rx_valid && (byte_cnt == 2'd3)) begin
                    state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (i_rx_valid && (byte_cnt == 2'd1)) begin
                    state_next = (len_word == 16'd0) ? S_CSUM : S_DATA;
                end
            end
            S_DATA: begin
                if (i_rx_valid && (byte_cnt == 2'd3) && (words_left == 16'd1)) begin
                    state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                if (i_rx_valid) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                o_tx_valid = 1'b1;
                o_tx_data  = resp_nak ? RESP_NAK : RESP_ACK;
                if (i_tx_ready) begin
                    state_next = (run_flag && !resp_nak) ? S_RUN : S_IDLE;
                end
            end
            S_RUN: begin
                o_busy    = 1'b0;
                o_cpu_rst = 1'b0;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (timeout_hit) begin
            state_next = S_IDLE;
        end
    end

    // Frame datapath: field capture, checksum, range check, word writes, timeout
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            byte_cnt   <= 2'd0;
            words_left <= 16'd0;
            addr_sr    <= 32'd0;
            len_hi     <= 8'd0;
            data_sr    <= 24'd0;
            csum       <= 8'd0;
            run_flag   <= 1'b0;
            range_err  <= 1'b0;
            resp_nak   <= 1'b0;
            wr_ptr     <= '0;
            tmo_cnt    <= '0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= 32'd0;
        end else begin
            mem_wr_q <= 1'b0;

            if (rx_state && !i_rx_valid && !timeout_hit) begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end else begin
                tmo_cnt <= '0;
            end

            if (i_rx_valid) begin
                case (state)
                    S_IDLE: begin
                        if (i_rx_data == SYNC_BYTE) begin
                            byte_cnt  <= 2'd0;
                            csum      <= 8'd0;
                            run_flag  <= 1'b0;
                            range_err <= 1'b0;
                            resp_nak  <= 1'b0;
                        end
                    end
                    S_CMD: begin
                        byte_cnt <= 2'd0;
                        if (i_rx_data == CMD_RUN) begin
                            run_flag <= 1'b1;
                        end else if (i_rx_data != CMD_WRITE) begin
                            resp_nak <= 1'b1;
                        end
                    end
                    S_ADDR: begin
                        addr_sr  <= {addr_sr[23:0], i_rx_data};
                        csum     <= csum + i_rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                    S_LEN: begin
                        csum <= csum + i_rx_data;
                        if (byte_cnt == 2'd0) begin
                            len_hi   <= i_rx_data;
                            byte_cnt <= 2'd1;
                        end else begin
                            words_left <= len_word;
                            range_err  <= range_bad;
                            wr_ptr     <= addr_sr[MEM_AW+1:2];
                            byte_cnt   <= 2'd0;
                        end
                    end
                    S_DATA: begin
                        csum     <= csum + i_rx_data;
                        data_sr  <= {data_sr[15:0], i_rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Out-of-range blocks are still consumed for the checksum but never written.
                            mem_wr_q   <= !range_err;
                            mem_addr_q <= wr_ptr;
                            mem_data_q <= {data_sr, i_rx_data};
                            wr_ptr     <= wr_ptr + MEM_AW'(1);
                            words_left <= words_left - 16'd1;
                        end
                    end
                    S_CSUM: begin
                        resp_nak <= (i_rx_data != csum) || range_err;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_mem_wr   = mem_wr_q;
    assign o_mem_addr = mem_addr_q;
    assign o_mem_data = mem_data_q;

endmodule
